// File: rtl/lynx_reset_pkg.sv
// Shared types and constants for the Lynx power-on / reset sequencer.
package lynx_reset_pkg;

  typedef enum logic [1:0] {
    S_POWER = 2'd0,
    S_HOLD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam int CAUSE_WARM = 0;
  localparam int CAUSE_OPT  = 1;
  localparam int CAUSE_COLD = 2;

endpackage

// File: rtl/option_change_detect.sv
// Registered change detector on the watched OSD option bits; each change is
// classed warm or cold by COLD_MASK. Flags are valid one ce tick after the change.
module option_change_detect #(
  parameter int              NOPT      = 2,
  parameter logic [NOPT-1:0] COLD_MASK = '0
) (
  input  logic            clock24,
  input  logic            reset,
  input  logic            ce_i,
  input  logic [NOPT-1:0] opt_i,
  output logic            chg_warm_o,
  output logic            chg_cold_o
);

  logic [NOPT-1:0] opt_q;
  logic            chg_warm_q;
  logic            chg_cold_q;
  logic [NOPT-1:0] diff;

  assign diff = opt_i ^ opt_q;

  // Reset captures the live options so the first value never looks like a change.
  always_ff @(posedge clock24) begin
    if (!reset) begin
      opt_q      <= opt_i;
      chg_warm_q <= 1'b0;
      chg_cold_q <= 1'b0;
    end else if (ce_i) begin
      opt_q      <= opt_i;
      chg_warm_q <= |(diff & ~COLD_MASK);
      chg_cold_q <= |(diff & COLD_MASK);
    end
  end

  assign chg_warm_o = chg_warm_q;
  assign chg_cold_o = chg_cold_q;

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / warm / cold reset sequencer driving power and core_run, stepped on ce.
// Optional RESET_CAUSE_EN adds a latched one-hot cause register; otherwise cause is 0.
module reset_sequencer
  import lynx_reset_pkg::*;
#(
  parameter int              NOPT         = 2,
  parameter int              POWER_CYCLES = 8,
  parameter int              RESET_CYCLES = 16,
  parameter logic [NOPT-1:0] COLD_MASK    = '0
) (
  input  logic            clock24,
  input  logic            reset,
  input  logic            ce,
  input  logic [NOPT-1:0] opt,
  input  logic            warm_req,
  input  logic            cold_req,
  output logic            power,
  output logic            core_run,
  output logic [2:0]      cause
);

  localparam int PW = $clog2(POWER_CYCLES + 1);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam logic [PW-1:0] PWR_LAST  = PW'(POWER_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   pwr_cnt_q, pwr_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            power_q, power_d;
  logic            core_run_q, core_run_d;
  logic            chg_warm, chg_cold;
  logic            cold_hit, warm_hit;

  option_change_detect #(
    .NOPT      (NOPT),
    .COLD_MASK (COLD_MASK)
  ) u_chg (
    .clock24    (clock24),
    .reset      (reset),
    .ce_i       (ce),
    .opt_i      (opt),
    .chg_warm_o (chg_warm),
    .chg_cold_o (chg_cold)
  );

  assign cold_hit = cold_req | chg_cold;
  assign warm_hit = warm_req | chg_warm;

  always_ff @(posedge clock24) begin
    if (!reset) begin
      state_q    <= S_POWER;
      pwr_cnt_q  <= '0;
      hold_cnt_q <= '0;
      power_q    <= 1'b0;
      core_run_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      power_q    <= power_d;
      core_run_q <= core_run_d;
    end
  end

  // Cold beats everything; non-cold requests during S_POWER are absorbed.
  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    hold_cnt_d = hold_cnt_q;
    power_d    = power_q;
    core_run_d = core_run_q;
    if (ce) begin
      if (cold_hit) begin
        state_d    = S_POWER;
        pwr_cnt_d  = '0;
        hold_cnt_d = '0;
        power_d    = 1'b0;
        core_run_d = 1'b0;
      end else begin
        case (state_q)
          S_POWER: begin
            if (pwr_cnt_q == PWR_LAST) begin
              state_d    = S_HOLD;
              power_d    = 1'b1;
              hold_cnt_d = '0;
            end else begin
              pwr_cnt_d = pwr_cnt_q + PW'(1);
            end
          end
          S_HOLD: begin
            if (warm_hit) begin
              hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
              state_d    = S_RUN;
              core_run_d = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + HW'(1);
            end
          end
          S_RUN: begin
            if (warm_hit) begin
              state_d    = S_HOLD;
              hold_cnt_d = '0;
              core_run_d = 1'b0;
            end
          end
          default: state_d = S_POWER;
        endcase
      end
    end
  end

  assign power    = power_q;
  assign core_run = core_run_q;

`ifdef RESET_CAUSE_EN
  logic [2:0] cause_q, cause_d;

  // Hold restarts also re-latch, so cause always names the latest request.
  always_comb begin
    cause_d = cause_q;
    if (ce && cold_hit) begin
      cause_d             = '0;
      cause_d[CAUSE_COLD] = 1'b1;
    end else if (ce && warm_hit && state_q != S_POWER) begin
      cause_d = '0;
      if (chg_warm) cause_d[CAUSE_OPT] = 1'b1;
      else          cause_d[CAUSE_WARM] = 1'b1;
    end
  end

  always_ff @(posedge clock24) begin
    if (!reset) cause_q <= 3'b100;
    else        cause_q <= cause_d;
  end

  assign cause = cause_q;
`else
  assign cause = 3'b000;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: countdown-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reset_sequencer;

  localparam int         P    = 8;
  localparam int         R    = 16;
  localparam logic [1:0] MASK = 2'b10;
`ifdef RESET_CAUSE_EN
  localparam bit CAUSE_ON = 1'b1;
`else
  localparam bit CAUSE_ON = 1'b0;
`endif

  logic       clock24, reset, ce, warm_req, cold_req;
  logic [1:0] opt;
  logic       power, core_run;
  logic [2:0] cause;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference: ticks of power-low and core_run-low still owed.
  int         m_pwr_left, m_hold_left;
  logic [1:0] m_prev;
  bit         m_cw, m_cc;
  logic [2:0] m_cause;

  reset_sequencer #(
    .NOPT         (2),
    .POWER_CYCLES (P),
    .RESET_CYCLES (R),
    .COLD_MASK    (MASK)
  ) dut (
    .clock24  (clock24),
    .reset    (reset),
    .ce       (ce),
    .opt      (opt),
    .warm_req (warm_req),
    .cold_req (cold_req),
    .power    (power),
    .core_run (core_run),
    .cause    (cause)
  );

  initial clock24 = 1'b0;
  always #5 clock24 = ~clock24;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock24);
    if (!reset) begin
      m_pwr_left  = P;
      m_hold_left = R;
      m_prev      = opt;
      m_cw        = 1'b0;
      m_cc        = 1'b0;
      m_cause     = 3'b100;
    end else if (ce) begin
      if (cold_req || m_cc) begin
        m_pwr_left  = P;
        m_hold_left = R;
        m_cause     = 3'b100;
      end else if (m_pwr_left > 0) begin
        m_pwr_left--;
      end else if (warm_req || m_cw) begin
        m_hold_left = R;
        m_cause     = m_cw ? 3'b010 : 3'b001;
      end else if (m_hold_left > 0) begin
        m_hold_left--;
      end
      m_cw   = |((opt ^ m_prev) & ~MASK);
      m_cc   = |((opt ^ m_prev) & MASK);
      m_prev = opt;
    end
  end

  initial forever begin
    @(negedge clock24);
    if (chk_en)
      check("cycle{power,run,cause}", {27'd0, power, core_run, cause},
            {27'd0, (m_pwr_left == 0), (m_pwr_left == 0 && m_hold_left == 0),
             (CAUSE_ON ? m_cause : 3'b000)});
  end

  task automatic ce_tick(input int gap);
    ce = 1'b0;
    repeat (gap) begin @(posedge clock24); #1; end
    ce = 1'b1;
    @(posedge clock24); #1;
    ce = 1'b0;
  endtask

  // Tick until the chosen output is high; low counts ticks after which it was still low.
  task automatic run_until_high(input bit use_power, inout int low, output int ticks);
    ticks = 0;
    while (((use_power ? power : core_run) == 1'b0) && ticks < 200) begin
      ce_tick(3);
      ticks++;
      if ((use_power ? power : core_run) == 1'b0) low++;
    end
    check("rise_timeout", 32'(ticks < 200), 32'd1);
  endtask

  task automatic power_on(input string tag);
    repeat (P - 1) ce_tick(3);
    check({tag, "_power_early"}, 32'(power), 32'd0);
    ce_tick(3);
    check({tag, "_power_up"}, 32'(power), 32'd1);
    check({tag, "_run_low"}, 32'(core_run), 32'd0);
    repeat (R - 1) ce_tick(3);
    check({tag, "_run_early"}, 32'(core_run), 32'd0);
    ce_tick(3);
    check({tag, "_run_up"}, 32'(core_run), 32'd1);
    check({tag, "_cause"}, 32'(cause), CAUSE_ON ? 32'd4 : 32'd0);
  endtask

  initial begin
    int low, ticks;
    reset = 1'b0; ce = 1'b0; opt = 2'b00; warm_req = 1'b0; cold_req = 1'b0;
    repeat (3) @(posedge clock24);
    #1;
    chk_en = 1'b1;
    check("rst_power", 32'(power), 32'd0);
    check("rst_run", 32'(core_run), 32'd0);
    check("rst_cause", 32'(cause), CAUSE_ON ? 32'd4 : 32'd0);

    reset = 1'b1;
    power_on("po");

    // Single-tick warm pulse.
    warm_req = 1'b1; ce_tick(3); warm_req = 1'b0;
    check("warm_run_low", 32'(core_run), 32'd0);
    check("warm_power", 32'(power), 32'd1);
    check("warm_cause", 32'(cause), CAUSE_ON ? 32'd1 : 32'd0);
    low = 1; run_until_high(1'b0, low, ticks);
    check("warm_low_len", low, R);

    // Warm-class option toggle, retoggled inside the hold.
    opt = 2'b01; ce_tick(3);
    check("opt_lat1_run", 32'(core_run), 32'd1);
    ce_tick(3);
    check("opt_lat2_run", 32'(core_run), 32'd0);
    check("opt_cause", 32'(cause), CAUSE_ON ? 32'd2 : 32'd0);
    low = 1;
    repeat (3) begin ce_tick(3); if (!core_run) low++; end
    opt = 2'b00; run_until_high(1'b0, low, ticks);
    check("opt_restart_len", low, 21);

    // Cold-class option change meeting a warm request on the same tick.
    opt = 2'b10; ce_tick(3);
    check("cold_lat1_run", 32'(core_run), 32'd1);
    warm_req = 1'b1; ce_tick(3); warm_req = 1'b0;
    check("cold_power", 32'(power), 32'd0);
    check("cold_run", 32'(core_run), 32'd0);
    check("cold_cause", 32'(cause), CAUSE_ON ? 32'd4 : 32'd0);
    low = 1; run_until_high(1'b1, low, ticks);
    check("cold_pwr_len", low, P);
    low = 1; run_until_high(1'b0, low, ticks);
    check("cold_hold_len", low, R);

    // Reset mid-hold with the options moving underneath it.
    warm_req = 1'b1; ce_tick(3); warm_req = 1'b0;
    repeat (3) ce_tick(3);
    reset = 1'b0; opt = 2'b01;
    ce_tick(3); ce_tick(0);
    check("midrst_power", 32'(power), 32'd0);
    check("midrst_run", 32'(core_run), 32'd0);
    reset = 1'b1;
    power_on("rst2");
    repeat (5) ce_tick(3);
    check("no_spurious_run", 32'(core_run), 32'd1);

    // ce frozen inside a hold.
    warm_req = 1'b1; ce_tick(3); warm_req = 1'b0;
    repeat (5) ce_tick(3);
    ce = 1'b0;
    repeat (100) @(posedge clock24);
    #1;
    check("freeze_run", 32'(core_run), 32'd0);
    check("freeze_power", 32'(power), 32'd1);
    low = 0; run_until_high(1'b0, low, ticks);
    check("freeze_resume_ticks", ticks, R - 5);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      warm_req = ($urandom_range(19) == 0);
      cold_req = ($urandom_range(99) == 0);
      if ($urandom_range(29) == 0) opt = opt ^ (2'b01 << $urandom_range(1));
      reset = ($urandom_range(299) != 0);
      ce_tick($urandom_range(3));
    end
    warm_req = 1'b0; cold_req = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clock24);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
